// File: rtl/mdio_master.sv
// Clause-22 MDIO management initiator: serialises one read/write command per frame
// onto MDC/MDIO and returns read data plus a turnaround-error flag.
module mdio_master #(
  parameter int unsigned CLK_DIV      = 10,
  parameter int unsigned PREAMBLE_LEN = 32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phyad,
  input  logic [4:0]  cmd_regad,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oen,
  input  logic        mdio_i
);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_TA, S_DATA, S_DONE} state_t;

  localparam logic [8:0] HALF     = 9'(CLK_DIV);
  localparam logic [8:0] LAST     = 9'(2 * CLK_DIV - 1);
  localparam logic [5:0] PRE_LAST = 6'(PREAMBLE_LEN - 1);

  state_t      state, state_n;
  logic [8:0]  half_cnt, half_n;
  logic [5:0]  bit_cnt, bit_n;
  logic        wr_q, wr_n;
  logic [31:0] tx_sr, tx_n;
  logic [15:0] rx_sr, rx_n;
  logic        err_q, err_n;
  logic        mdc_n, o_n, oen_n, rv_n, re_n;
  logic [15:0] rd_n;
  logic [31:0] frame;
  logic        sync1, sync2;

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

  always_comb begin
    state_n = state;
    half_n  = half_cnt;
    bit_n   = bit_cnt;
    wr_n    = wr_q;
    tx_n    = tx_sr;
    rx_n    = rx_sr;
    err_n   = err_q;
    mdc_n   = mdc;
    o_n     = mdio_o;
    oen_n   = mdio_oen;
    rv_n    = 1'b0;
    rd_n    = rsp_rdata;
    re_n    = rsp_err;
    frame   = '0;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          // Reads carry ones after REGAD; those bits are never driven (oen high).
          frame = {2'b01, (cmd_write ? 2'b01 : 2'b10), cmd_phyad, cmd_regad,
                   (cmd_write ? {2'b10, cmd_wdata} : 18'h3FFFF)};
          wr_n   = cmd_write;
          half_n = '0;
          bit_n  = '0;
          rx_n   = '0;
          err_n  = 1'b0;
          mdc_n  = 1'b0;
          oen_n  = 1'b0;
          if (PREAMBLE_LEN != 0) begin
            state_n = S_PRE;
            o_n     = 1'b1;
            tx_n    = frame;
          end else begin
            state_n = S_HDR;
            o_n     = frame[31];
            tx_n    = {frame[30:0], 1'b0};
          end
        end
      end
      S_DONE: state_n = S_IDLE;
      default: begin
        if (half_cnt != LAST) begin
          half_n = half_cnt + 9'd1;
          mdc_n  = (half_cnt + 9'd1 >= HALF);
        end else begin
          // Last high-phase cycle: sample, then open the next bit.
          half_n = '0;
          mdc_n  = 1'b0;
          bit_n  = bit_cnt + 6'd1;
          if (!wr_q && state == S_TA && bit_cnt == 6'd1) err_n = sync2;
          if (!wr_q && state == S_DATA) rx_n = {rx_sr[14:0], sync2};
          case (state)
            S_PRE:  if (bit_cnt == PRE_LAST) begin state_n = S_HDR;  bit_n = '0; end
            S_HDR:  if (bit_cnt == 6'd13) begin
                      state_n = S_TA;
                      bit_n   = '0;
                      oen_n   = !wr_q;
                    end
            S_TA:   if (bit_cnt == 6'd1)  begin state_n = S_DATA; bit_n = '0; end
            S_DATA: if (bit_cnt == 6'd15) begin state_n = S_DONE; bit_n = '0; end
            default: ;
          endcase
          if (state_n == S_DONE) begin
            o_n   = 1'b1;
            oen_n = 1'b1;
            rv_n  = 1'b1;
            rd_n  = wr_q ? 16'h0000 : rx_n;
            re_n  = wr_q ? 1'b0 : err_n;
          end else if (state_n != S_PRE) begin
            o_n  = tx_sr[31];
            tx_n = {tx_sr[30:0], 1'b0};
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      half_cnt  <= '0;
      bit_cnt   <= '0;
      wr_q      <= 1'b0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      err_q     <= 1'b0;
      mdc       <= 1'b0;
      mdio_o    <= 1'b1;
      mdio_oen  <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      sync1     <= 1'b1;
      sync2     <= 1'b1;
    end else begin
      state     <= state_n;
      half_cnt  <= half_n;
      bit_cnt   <= bit_n;
      wr_q      <= wr_n;
      tx_sr     <= tx_n;
      rx_sr     <= rx_n;
      err_q     <= err_n;
      mdc       <= mdc_n;
      mdio_o    <= o_n;
      mdio_oen  <= oen_n;
      rsp_valid <= rv_n;
      rsp_rdata <= rd_n;
      rsp_err   <= re_n;
      sync1     <= mdio_i;
      sync2     <= sync1;
    end
  end

endmodule
